// File: rtl/universal_shift_register.sv
// universal_shift_register: configurable-width universal shift register with counted burst engine.
// Optional Parity output is enabled by defining USR_PARITY_EN.
module universal_shift_register #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [2:0]       Mode,
   input  logic             Start,
   input  logic [CNT_W-1:0] Shift_Count,
   input  logic [WIDTH-1:0] Data_In,
   input  logic             Serial_In_L,
   input  logic             Serial_In_R,
   output logic [WIDTH-1:0] Q,
   output logic             Serial_Out_L,
   output logic             Serial_Out_R,
   output logic             Busy,
   output logic             Done
`ifdef USR_PARITY_EN
   ,output logic            Parity
`endif
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       lmode;
   logic [2:0]       m;
   logic             shift_mode;
   logic             arm;
   logic [WIDTH-1:0] q_next;

   assign Serial_Out_L = Q[WIDTH-1];
   assign Serial_Out_R = Q[0];
   assign shift_mode = (Mode != 3'b000) && (Mode != 3'b011) && (Mode != 3'b111);
   // A burst request consumes its edge for latching; Q holds
   assign arm = (state == IDLE) && Start && shift_mode;
   assign m = (state == RUN) ? lmode : Mode;

   always_comb begin
      q_next = Q;
      case (m)
         3'b001: q_next = {Serial_In_L, Q[WIDTH-1:1]};
         3'b010: q_next = {Q[WIDTH-2:0], Serial_In_R};
         3'b011: q_next = Data_In;
         3'b100: q_next = {Q[0], Q[WIDTH-1:1]};
         3'b101: q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
         3'b110: q_next = {Q[WIDTH-1], Q[WIDTH-1:1]};
         3'b111: q_next = '0;
         default: q_next = Q;
      endcase
      if (arm) q_next = Q;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         lmode <= 3'b000;
         Q     <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         Q    <= q_next;
         Done <= 1'b0;
         if (state == IDLE) begin
            if (arm) begin
               lmode <= Mode;
               cnt   <= Shift_Count;
               if (Shift_Count != '0) begin
                  state <= RUN;
                  Busy  <= 1'b1;
               end else begin
                  Done <= 1'b1;
               end
            end
         end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b1;
            end
         end
      end
   end

`ifdef USR_PARITY_EN
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) Parity <= 1'b0;
      else Parity <= ^q_next;
   end
`endif
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed self-checking bench for universal_shift_register (WIDTH=8, CNT_W=4).
module tb_universal_shift_register;
   logic       Clock = 1'b0;
   logic       run_clk = 1'b1;
   logic       Reset = 1'b1;
   logic [2:0] Mode = 3'b000;
   logic       Start = 1'b0;
   logic [3:0] Shift_Count = 4'd0;
   logic [7:0] Data_In = 8'h00;
   logic       Serial_In_L = 1'b0;
   logic       Serial_In_R = 1'b0;
   logic [7:0] Q;
   logic       Serial_Out_L, Serial_Out_R, Busy, Done;
`ifdef USR_PARITY_EN
   logic       Parity;
`endif
   int checks = 0;
   int failures = 0;

   universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
      .Clock(Clock), .Reset(Reset), .Mode(Mode), .Start(Start),
      .Shift_Count(Shift_Count), .Data_In(Data_In),
      .Serial_In_L(Serial_In_L), .Serial_In_R(Serial_In_R),
      .Q(Q), .Serial_Out_L(Serial_Out_L), .Serial_Out_R(Serial_Out_R),
      .Busy(Busy), .Done(Done)
`ifdef USR_PARITY_EN
      ,.Parity(Parity)
`endif
   );

   always begin
      #5;
      if (run_clk) Clock = ~Clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      tick();
      Reset = 1'b0;
      // get non-zero state and a live burst before the stopped-clock reset
      Mode = 3'b011; Data_In = 8'hFF;
      tick();
      check("load_ff", Q, 8'hFF);
      Start = 1'b1; Mode = 3'b001; Shift_Count = 4'd3;
      tick();
      check("pre_busy", Busy, 1);
      Start = 1'b0; Mode = 3'b000;
      @(negedge Clock);
      run_clk = 1'b0;
      #2 Reset = 1'b1;
      #1;
      check("rst_q", Q, 8'h00);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_sol", Serial_Out_L, 0);
      check("rst_sor", Serial_Out_R, 0);
`ifdef USR_PARITY_EN
      check("rst_par", Parity, 0);
`endif
      #2 Reset = 1'b0;
      run_clk = 1'b1;
      tick();
      // load and hold
      Mode = 3'b011; Data_In = 8'hB4;
      tick();
      check("load_b4", Q, 8'hB4);
      Mode = 3'b000;
      repeat (3) tick();
      check("hold_q", Q, 8'hB4);
      check("hold_sol", Serial_Out_L, 1);
      check("hold_sor", Serial_Out_R, 0);
      // rotate-right burst of 3, Mode/Data_In changes ignored during RUN
      Start = 1'b1; Mode = 3'b100; Shift_Count = 4'd3;
      tick();
      check("rr_arm_q", Q, 8'hB4);
      check("rr_arm_busy", Busy, 1);
      Start = 1'b0; Mode = 3'b011; Data_In = 8'h00;
      tick();
      check("rr1", Q, 8'h5A);
      tick();
      check("rr2", Q, 8'h2D);
      check("rr2_busy", Busy, 1);
      check("rr2_done", Done, 0);
      tick();
      check("rr3", Q, 8'h96);
      check("rr3_busy", Busy, 0);
      check("rr3_done", Done, 1);
`ifdef USR_PARITY_EN
      check("rr3_par", Parity, 0);
`endif
      // back-to-back ASR burst started while Done is high
      Start = 1'b1; Mode = 3'b110; Shift_Count = 4'd2;
      tick();
      check("asr_arm_q", Q, 8'h96);
      check("asr_arm_busy", Busy, 1);
      check("asr_arm_done", Done, 0);
      Start = 1'b0; Mode = 3'b111;
      tick();
      check("asr1", Q, 8'hCB);
      tick();
      check("asr2", Q, 8'hE5);
      check("asr2_done", Done, 1);
      Mode = 3'b000;
      tick();
      check("asr_done_clr", Done, 0);
      check("asr_hold", Q, 8'hE5);
      // shift-left burst of 4 with Serial_In_R=1
      Mode = 3'b011; Data_In = 8'h01;
      tick();
      Start = 1'b1; Mode = 3'b010; Serial_In_R = 1'b1; Shift_Count = 4'd4;
      tick();
      Start = 1'b0; Mode = 3'b000;
      repeat (3) tick();
      check("sl3_busy", Busy, 1);
      check("sl3_q", Q, 8'h0F);
      tick();
      check("sl4_q", Q, 8'h1F);
      check("sl4_done", Done, 1);
      check("sl4_busy", Busy, 0);
      // zero-length burst
      Start = 1'b1; Mode = 3'b010; Shift_Count = 4'd0;
      tick();
      check("n0_done", Done, 1);
      check("n0_busy", Busy, 0);
      check("n0_q", Q, 8'h1F);
      Start = 1'b0; Mode = 3'b000;
      tick();
      check("n0_done_clr", Done, 0);
      check("n0_busy2", Busy, 0);
      // idle single-edge ops
      Mode = 3'b001; Serial_In_L = 1'b1;
      tick();
      check("idle_sr", Q, 8'h8F);
      Mode = 3'b101;
      tick();
      check("idle_rl", Q, 8'h1F);
      Mode = 3'b111;
      tick();
      check("idle_clr", Q, 8'h00);
      // Start with a non-shift mode is ignored
      Start = 1'b1; Mode = 3'b011; Data_In = 8'hA5; Shift_Count = 4'd3;
      tick();
      check("ns_q", Q, 8'hA5);
      check("ns_busy", Busy, 0);
      check("ns_done", Done, 0);
      // burst aborted by async reset after two operations
      Mode = 3'b001; Serial_In_L = 1'b0; Shift_Count = 4'd5;
      tick();
      Start = 1'b0; Mode = 3'b000;
      tick();
      check("ab1", Q, 8'h52);
      tick();
      check("ab2", Q, 8'h29);
      #2 Reset = 1'b1;
      #1;
      check("ab_rst_q", Q, 8'h00);
      check("ab_rst_busy", Busy, 0);
      tick();
      Reset = 1'b0;
      repeat (4) begin
         tick();
         check("ab_no_done", {Busy, Done}, 2'b00);
      end
      Mode = 3'b011; Data_In = 8'h3C;
      tick();
      check("post_rst_load", Q, 8'h3C);
      // count larger than WIDTH saturates a logical shift
      Start = 1'b1; Mode = 3'b010; Serial_In_R = 1'b0; Shift_Count = 4'd15;
      tick();
      Start = 1'b0; Mode = 3'b000;
      begin
         int n = 0;
         while (Busy && n < 20) begin
            tick();
            n++;
         end
         check("sat_len", n, 15);
      end
      check("sat_q", Q, 8'h00);
      check("sat_done", Done, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
